multi_branch_amend: RTL and testbench
=====================================

Name: multi_branch_amend

Overview:
- Multi-lane successor to the single-lane PREMEM branch-amend stage; sits between EXE and PREMEM.
- Registers up to LANES branch/ALU results per cycle, one per issue lane.
- Selects the oldest lane whose branch needs repair and issues a one-shot flush with its correction info.
- Squashes younger lanes in the same bundle; honours the MEM risk interlock and MEM-level exception flush.

Parameters:
- LANES, 2, issue lanes per bundle; lane 0 is oldest.
- DATA_W, 32, width of address and data words.
- GPR_W, 5, register-number width.
- CKPT_W, 8, checkpoint field width per lane.
- RA_W, 4, repair-action field width per lane.
- NEED_REPAIR_BIT, 0, bit index inside repair action meaning "repair required".

Ports:
- clk  in  1  clock
- rst  in  1  reset
- mem_has_risk_i  in  1  MEM stage holds unresolved risk; blocks repair
- exc_occur_i  in  1  CP0 exception taken
- exc_mem_seg_i  in  1  exception belongs to MEM segment
- in_valid_i  in  1  EXE bundle valid
- in_lane_valid_i  in  LANES  per-lane valid inside bundle
- premem_allowin_i  in  1  downstream accepts
- in_write_num_i  in  LANES*GPR_W  destination registers
- in_vaddr_i  in  LANES*DATA_W  instruction PCs
- in_alu_res_i  in  LANES*DATA_W  ALU results
- in_corr_dest_i  in  LANES*DATA_W  resolved targets
- in_corr_take_i  in  LANES  resolved directions
- in_repair_i  in  LANES*RA_W  repair actions
- in_ckpt_i  in  LANES*CKPT_W  checkpoints
- ok_to_change_o  out  1  stage can accept or drain
- out_valid_o  out  1  bundle forwarded to PREMEM this cycle
- out_lane_valid_o  out  LANES  surviving lanes (younger than flushing lane cleared)
- fwd_mode_o  out  1  forwarding data valid
- out_write_num_o  out  LANES*GPR_W  registered dests
- out_vaddr_o  out  LANES*DATA_W  registered PCs
- out_alu_res_o  out  LANES*DATA_W  registered results
- flush_o  out  1  branch-mispredict flush pulse
- flush_lane_o  out  clog2(LANES) (min 1)  lane index that caused flush
- err_vaddr_o  out  DATA_W  PC of flushing branch
- corr_dest_o  out  DATA_W  correct target
- corr_take_o  out  1  correct direction
- ckpt_o  out  CKPT_W  checkpoint of flushing lane
- repair_o  out  RA_W  repair action of flushing lane

Behaviour:
- Reset: rst is synchronous, active-low; clock is clk. When rst=0, all stored fields, has_data, lane mask and flush_done clear to 0. Outputs then: out_valid_o=0, flush_o=0, out_lane_valid_o=0, fwd_mode_o=0, ok_to_change_o=1, all data outputs 0.
- need_rep = OR over stored lanes of (lane_valid & repair[NEED_REPAIR_BIT]).
- ready = !(mem_has_risk_i & need_rep).
- ok_to_change_o = !has_data | ready.
- exc_flush = exc_occur_i & exc_mem_seg_i.
- pre_valid = in_valid_i & !flush_o.
- Update (premem_allowin_i & pre_valid & !exc_flush): capture all lane fields and the lane mask; has_data<=1; flush_done<=0.
- Clear ((premem_allowin_i & !pre_valid) | exc_flush): all fields zero, has_data<=0, flush_done<=0. Clear has priority over update.
- Otherwise hold.
- Selection: sel = lowest index i with lane_valid[i] & repair_i[NEED_REPAIR_BIT]. flush_lane_o, err_vaddr_o, corr_dest_o, corr_take_o, ckpt_o and repair_o are combinational muxes of lane sel. When no lane is selected, they equal lane 0 fields.
- flush_o = has_data & need_rep & !mem_has_risk_i & !flush_done. This is a one-cycle pulse per captured bundle; flush_done sets the cycle after flush_o=1.
- out_lane_valid_o[j] = lane_valid[j] & !(need_rep & j>sel). The flushing lane itself stays valid.
- out_valid_o = has_data & ready & premem_allowin_i & !exc_flush.
- fwd_mode_o = has_data & ready.
- Latency: EXE to outputs is 1 cycle. The flush decision is combinational from registered state.
- Simultaneous flush_o and in_valid_i: the incoming bundle is dropped (wrong path).
- Simultaneous exc_flush and flush_o: flush_o is still driven; CP0 dominates externally; the stage clears next cycle.
- Risk deasserting while stalled: flush_o fires in the first risk-free cycle, exactly once.
- Reset mid-stall discards the bundle; no flush is issued.

Test Plan:
- Lane 1 of 2 needs repair, risk=0, allowin=1 -> flush_o=1 for exactly 1 cycle, flush_lane_o=1, corr_dest_o=lane1 dest (0x8000_1000), out_lane_valid_o=2'b11.
- Lanes 0 and 1 both need repair -> flush_lane_o=0, out_lane_valid_o=2'b01, err_vaddr_o=lane0 PC 0xBFC0_0100.
- Repair needed with mem_has_risk_i=1 for 3 cycles -> ok_to_change_o=0, flush_o=0, out_valid_o=0; risk drops -> flush_o pulses once, out_valid_o=1.
- exc_occur_i=1 & exc_mem_seg_i=1 while holding a bundle -> next cycle has_data=0, out_valid_o=0, no flush.
- in_valid_i=1 during flush_o cycle -> the new bundle is not captured; out_lane_valid_o=0 next cycle.
- rst=0 asserted mid-stall with a pending repair -> all outputs 0, ok_to_change_o=1, flush_o never asserts afterwards.

Source files
------------

// File: rtl/multi_branch_amend.sv
// Multi-lane branch-amend stage between EXE and PREMEM: registers one bundle,
// picks the oldest lane needing repair and issues a one-shot mispredict flush.
module multi_branch_amend #(
    parameter int LANES           = 2,
    parameter int DATA_W          = 32,
    parameter int GPR_W           = 5,
    parameter int CKPT_W          = 8,
    parameter int RA_W            = 4,
    parameter int NEED_REPAIR_BIT = 0,
    localparam int SEL_W          = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_has_risk_i,
    input  logic                      exc_occur_i,
    input  logic                      exc_mem_seg_i,
    input  logic                      in_valid_i,
    input  logic [LANES-1:0]          in_lane_valid_i,
    input  logic                      premem_allowin_i,
    input  logic [LANES*GPR_W-1:0]    in_write_num_i,
    input  logic [LANES*DATA_W-1:0]   in_vaddr_i,
    input  logic [LANES*DATA_W-1:0]   in_alu_res_i,
    input  logic [LANES*DATA_W-1:0]   in_corr_dest_i,
    input  logic [LANES-1:0]          in_corr_take_i,
    input  logic [LANES*RA_W-1:0]     in_repair_i,
    input  logic [LANES*CKPT_W-1:0]   in_ckpt_i,
    output logic                      ok_to_change_o,
    output logic                      out_valid_o,
    output logic [LANES-1:0]          out_lane_valid_o,
    output logic                      fwd_mode_o,
    output logic [LANES*GPR_W-1:0]    out_write_num_o,
    output logic [LANES*DATA_W-1:0]   out_vaddr_o,
    output logic [LANES*DATA_W-1:0]   out_alu_res_o,
    output logic                      flush_o,
    output logic [SEL_W-1:0]          flush_lane_o,
    output logic [DATA_W-1:0]         err_vaddr_o,
    output logic [DATA_W-1:0]         corr_dest_o,
    output logic                      corr_take_o,
    output logic [CKPT_W-1:0]         ckpt_o,
    output logic [RA_W-1:0]           repair_o
);

    logic                              has_data;
    logic                              flush_done;
    logic [LANES-1:0]                  lane_valid_q;
    logic [LANES-1:0][GPR_W-1:0]       write_num_q;
    logic [LANES-1:0][DATA_W-1:0]      vaddr_q;
    logic [LANES-1:0][DATA_W-1:0]      alu_res_q;
    logic [LANES-1:0][DATA_W-1:0]      corr_dest_q;
    logic [LANES-1:0]                  corr_take_q;
    logic [LANES-1:0][RA_W-1:0]        repair_q;
    logic [LANES-1:0][CKPT_W-1:0]      ckpt_q;

    logic             need_rep;
    logic [SEL_W-1:0] sel;
    logic             ready;
    logic             exc_flush;
    logic             pre_valid;
    logic             do_update;
    logic             do_clear;

    // Descending scan so the lowest (oldest) matching lane wins.
    always_comb begin
        need_rep = 1'b0;
        sel      = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (lane_valid_q[i] && repair_q[i][NEED_REPAIR_BIT]) begin
                need_rep = 1'b1;
                sel      = SEL_W'(i);
            end
        end
    end

    assign ready     = !(mem_has_risk_i && need_rep);
    assign exc_flush = exc_occur_i && exc_mem_seg_i;
    assign flush_o   = has_data && need_rep && !mem_has_risk_i && !flush_done;
    assign pre_valid = in_valid_i && !flush_o;
    assign do_clear  = (premem_allowin_i && !pre_valid) || exc_flush;
    assign do_update = premem_allowin_i && pre_valid && !exc_flush;

    always_ff @(posedge clk) begin
        if (!rst || do_clear) begin
            has_data     <= 1'b0;
            flush_done   <= 1'b0;
            lane_valid_q <= '0;
            write_num_q  <= '0;
            vaddr_q      <= '0;
            alu_res_q    <= '0;
            corr_dest_q  <= '0;
            corr_take_q  <= '0;
            repair_q     <= '0;
            ckpt_q       <= '0;
        end else if (do_update) begin
            has_data     <= 1'b1;
            flush_done   <= 1'b0;
            lane_valid_q <= in_lane_valid_i;
            corr_take_q  <= in_corr_take_i;
            for (int i = 0; i < LANES; i++) begin
                write_num_q[i] <= in_write_num_i[i*GPR_W +: GPR_W];
                vaddr_q[i]     <= in_vaddr_i[i*DATA_W +: DATA_W];
                alu_res_q[i]   <= in_alu_res_i[i*DATA_W +: DATA_W];
                corr_dest_q[i] <= in_corr_dest_i[i*DATA_W +: DATA_W];
                repair_q[i]    <= in_repair_i[i*RA_W +: RA_W];
                ckpt_q[i]      <= in_ckpt_i[i*CKPT_W +: CKPT_W];
            end
        end else if (flush_o) begin
            flush_done <= 1'b1;
        end
    end

    // Lanes younger than the flushing lane are wrong-path; the flusher survives.
    always_comb begin
        out_lane_valid_o = '0;
        for (int j = 0; j < LANES; j++) begin
            out_lane_valid_o[j] = lane_valid_q[j] && !(need_rep && (SEL_W'(j) > sel));
        end
    end

    assign ok_to_change_o  = !has_data || ready;
    assign out_valid_o     = has_data && ready && premem_allowin_i && !exc_flush;
    assign fwd_mode_o      = has_data && ready;
    assign out_write_num_o = write_num_q;
    assign out_vaddr_o     = vaddr_q;
    assign out_alu_res_o   = alu_res_q;

    assign flush_lane_o = sel;
    assign err_vaddr_o  = vaddr_q[sel];
    assign corr_dest_o  = corr_dest_q[sel];
    assign corr_take_o  = corr_take_q[sel];
    assign ckpt_o       = ckpt_q[sel];
    assign repair_o     = repair_q[sel];

endmodule

// File: tb/tb_multi_branch_amend.sv
// Directed bench for multi_branch_amend: expectations queued per step and
// popped against the DUT outputs mid-cycle.
module tb_multi_branch_amend;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_has_risk_i, exc_occur_i, exc_mem_seg_i;
    logic        in_valid_i, premem_allowin_i;
    logic [1:0]  in_lane_valid_i;
    logic [9:0]  in_write_num_i;
    logic [63:0] in_vaddr_i, in_alu_res_i, in_corr_dest_i;
    logic [1:0]  in_corr_take_i;
    logic [7:0]  in_repair_i;
    logic [15:0] in_ckpt_i;
    logic        ok_to_change_o, out_valid_o, fwd_mode_o, flush_o, corr_take_o;
    logic [1:0]  out_lane_valid_o;
    logic [9:0]  out_write_num_o;
    logic [63:0] out_vaddr_o, out_alu_res_o;
    logic [0:0]  flush_lane_o;
    logic [31:0] err_vaddr_o, corr_dest_o;
    logic [7:0]  ckpt_o;
    logic [3:0]  repair_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic        ok, ov, fwd, fl, ln;
        logic [1:0]  lv;
        logic [31:0] ev, cd;
    } exp_t;
    exp_t sb[$];

    multi_branch_amend dut (
        .clk(clk), .rst(rst),
        .mem_has_risk_i(mem_has_risk_i), .exc_occur_i(exc_occur_i),
        .exc_mem_seg_i(exc_mem_seg_i), .in_valid_i(in_valid_i),
        .in_lane_valid_i(in_lane_valid_i), .premem_allowin_i(premem_allowin_i),
        .in_write_num_i(in_write_num_i), .in_vaddr_i(in_vaddr_i),
        .in_alu_res_i(in_alu_res_i), .in_corr_dest_i(in_corr_dest_i),
        .in_corr_take_i(in_corr_take_i), .in_repair_i(in_repair_i),
        .in_ckpt_i(in_ckpt_i), .ok_to_change_o(ok_to_change_o),
        .out_valid_o(out_valid_o), .out_lane_valid_o(out_lane_valid_o),
        .fwd_mode_o(fwd_mode_o), .out_write_num_o(out_write_num_o),
        .out_vaddr_o(out_vaddr_o), .out_alu_res_o(out_alu_res_o),
        .flush_o(flush_o), .flush_lane_o(flush_lane_o),
        .err_vaddr_o(err_vaddr_o), .corr_dest_o(corr_dest_o),
        .corr_take_o(corr_take_o), .ckpt_o(ckpt_o), .repair_o(repair_o)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
            $error("%s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic expect_now(input string tag, input logic ok, input logic ov,
                              input logic fwd, input logic fl, input logic [1:0] lv,
                              input logic ln, input logic [31:0] ev, input logic [31:0] cd);
        exp_t e;
        e.tag = tag; e.ok = ok; e.ov = ov; e.fwd = fwd; e.fl = fl;
        e.lv = lv; e.ln = ln; e.ev = ev; e.cd = cd;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        cmp({e.tag, ".ok"},   64'(ok_to_change_o),   64'(e.ok));
        cmp({e.tag, ".ov"},   64'(out_valid_o),      64'(e.ov));
        cmp({e.tag, ".fwd"},  64'(fwd_mode_o),       64'(e.fwd));
        cmp({e.tag, ".fl"},   64'(flush_o),          64'(e.fl));
        cmp({e.tag, ".lv"},   64'(out_lane_valid_o), 64'(e.lv));
        cmp({e.tag, ".ln"},   64'(flush_lane_o),     64'(e.ln));
        cmp({e.tag, ".ev"},   64'(err_vaddr_o),      64'(e.ev));
        cmp({e.tag, ".cd"},   64'(corr_dest_o),      64'(e.cd));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bundle(input logic v, input logic [1:0] lv, input logic r0, input logic r1);
        in_valid_i      = v;
        in_lane_valid_i = lv;
        in_repair_i     = {3'b000, r1, 3'b000, r0};
    endtask

    localparam logic [31:0] PC0 = 32'hBFC0_0100, PC1 = 32'hBFC0_0104;
    localparam logic [31:0] CD0 = 32'h8000_0800, CD1 = 32'h8000_1000;

    initial begin
        rst = 1'b0;
        mem_has_risk_i = 0; exc_occur_i = 0; exc_mem_seg_i = 0;
        premem_allowin_i = 0;
        bundle(0, 2'b00, 0, 0);
        in_write_num_i = {5'd9, 5'd3};
        in_vaddr_i     = {PC1, PC0};
        in_alu_res_i   = {32'h0000_2222, 32'h0000_1111};
        in_corr_dest_i = {CD1, CD0};
        in_corr_take_i = 2'b10;
        in_ckpt_i      = {8'hB1, 8'hA0};
        repeat (2) @(posedge clk);
        @(negedge clk);
        expect_now("reset", 1, 0, 0, 0, 2'b00, 0, 0, 0);
        cmp("reset.vaddr", out_vaddr_o, 64'h0);
        rst = 1'b1;

        // lane 1 mispredicts: single flush, held while downstream stalls
        bundle(1, 2'b11, 0, 1); premem_allowin_i = 1;
        expect_now("l1.pre", 1, 0, 0, 0, 2'b00, 0, 0, 0);
        tick();
        bundle(0, 2'b00, 0, 0); premem_allowin_i = 0;
        expect_now("l1.flush", 1, 0, 1, 1, 2'b11, 1, PC1, CD1);
        cmp("l1.take", 64'(corr_take_o), 64'h1);
        cmp("l1.ckpt", 64'(ckpt_o), 64'hB1);
        tick();
        expect_now("l1.once", 1, 0, 1, 0, 2'b11, 1, PC1, CD1);
        premem_allowin_i = 1;
        expect_now("l1.drain", 1, 1, 1, 0, 2'b11, 1, PC1, CD1);
        tick();
        expect_now("l1.empty", 1, 0, 0, 0, 2'b00, 0, 0, 0);

        // both lanes mispredict: oldest wins, lane 1 squashed
        bundle(1, 2'b11, 1, 1);
        tick();
        bundle(0, 2'b00, 0, 0);
        expect_now("both.flush", 1, 1, 1, 1, 2'b01, 0, PC0, CD0);
        tick();
        expect_now("both.empty", 1, 0, 0, 0, 2'b00, 0, 0, 0);

        // risk stall then release
        bundle(1, 2'b11, 0, 1);
        tick();
        bundle(0, 2'b00, 0, 0); premem_allowin_i = 0; mem_has_risk_i = 1;
        for (int k = 0; k < 3; k++) begin
            expect_now("risk.stall", 0, 0, 0, 0, 2'b11, 1, PC1, CD1);
            tick();
        end
        mem_has_risk_i = 0; premem_allowin_i = 1;
        expect_now("risk.release", 1, 1, 1, 1, 2'b11, 1, PC1, CD1);
        tick();
        expect_now("risk.after", 1, 0, 0, 0, 2'b00, 0, 0, 0);

        // MEM exception clears the held bundle
        bundle(1, 2'b11, 0, 0);
        tick();
        bundle(0, 2'b00, 0, 0); premem_allowin_i = 0;
        exc_occur_i = 1; exc_mem_seg_i = 1;
        expect_now("exc.hold", 1, 0, 1, 0, 2'b11, 0, PC0, CD0);
        tick();
        exc_occur_i = 0; exc_mem_seg_i = 0;
        expect_now("exc.cleared", 1, 0, 0, 0, 2'b00, 0, 0, 0);

        // bundle arriving during a flush is wrong-path
        premem_allowin_i = 1;
        bundle(1, 2'b11, 0, 1);
        tick();
        bundle(1, 2'b11, 0, 0);
        expect_now("drop.flush", 1, 1, 1, 1, 2'b11, 1, PC1, CD1);
        tick();
        bundle(0, 2'b00, 0, 0); premem_allowin_i = 0;
        expect_now("drop.after", 1, 0, 0, 0, 2'b00, 0, 0, 0);

        // reset during a risk stall discards the pending repair
        premem_allowin_i = 1;
        bundle(1, 2'b11, 0, 1);
        tick();
        bundle(0, 2'b00, 0, 0); premem_allowin_i = 0; mem_has_risk_i = 1;
        expect_now("rst.stall", 0, 0, 0, 0, 2'b11, 1, PC1, CD1);
        rst = 1'b0;
        tick();
        rst = 1'b1; mem_has_risk_i = 0;
        for (int k = 0; k < 2; k++) begin
            expect_now("rst.after", 1, 0, 0, 0, 2'b00, 0, 0, 0);
            tick();
        end
        cmp("rst.alu", out_alu_res_o, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
